// File: rtl/timer_pkg.sv
// Shared encodings for the timer arbiter: job modes, FSM states and small helpers.
package timer_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    ONE_SHOT        = 2'b00,
    DELAYED_OPERATE = 2'b01,
    DUAL_DELAY      = 2'b10,
    MODE_RSVD       = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_PHASE_A = 3'd2,
    ST_PHASE_B = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Modes that hold out high during PHASE_A and then run a low PHASE_B.
  function automatic logic has_phase_b(input mode_e m);
    return (m == DELAYED_OPERATE) || (m == DUAL_DELAY);
  endfunction

  function automatic logic [2:0] oh_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin picker: first set request strictly after rr_ptr, wrapping around.
module rr_select
  import timer_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] pick,
  output logic             valid
);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    valid = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one timer engine among N_REQ requesters.
// Define TIMER_ARB_ABORT_EN to abort a running job when its owner drops req.
module timer_arbiter
  import timer_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     mode,
  input  logic [CNT_W*N_REQ-1:0] weight,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       aborted,
  output logic                   out,
  output logic                   busy
);

  localparam int PTR_W = $clog2(N_REQ);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   rr_ptr_q;
  mode_e              mode_q;
  logic [CNT_W-1:0]   weight_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   w_last;
  logic [N_REQ-1:0]   pick;
  logic               valid;
  logic [PTR_W-1:0]   pick_idx;
  logic [N_REQ-1:0]   owner_oh;
  logic [1:0]         cur_mode;
  logic [CNT_W-1:0]   cur_weight;
  logic               abort_hit;

  rr_select #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr_select (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .pick   (pick),
    .valid  (valid)
  );

  assign pick_idx = PTR_W'(oh_to_idx(MAX_REQ'(pick)));
  assign owner_oh = N_REQ'(1) << owner_q;
  assign w_last   = weight_q - CNT_W'(1);

  // Live mode/weight of the chosen requester; only sampled while in LOAD.
  always_comb begin
    cur_mode   = '0;
    cur_weight = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == PTR_W'(i)) begin
        cur_mode   = mode[2*i +: 2];
        cur_weight = weight[CNT_W*i +: CNT_W];
      end
    end
  end

`ifdef TIMER_ARB_ABORT_EN
  assign abort_hit = ((state_q == ST_PHASE_A) || (state_q == ST_PHASE_B)) && !req[owner_q];
`else
  assign abort_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= PTR_W'(N_REQ - 1);
      mode_q   <= ONE_SHOT;
      weight_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_LOAD) begin
        mode_q   <= mode_e'(cur_mode);
        weight_q <= cur_weight;
        rr_ptr_q <= owner_q;
      end
    end
  end

  // The counter is cleared on every phase change and only advances while staying in a phase.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          owner_d = pick_idx;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = (cur_weight == '0) ? ST_DONE : ST_PHASE_A;
      ST_PHASE_A: begin
        if (abort_hit)             state_d = ST_IDLE;
        else if (cnt_q == w_last)  state_d = has_phase_b(mode_q) ? ST_PHASE_B : ST_DONE;
        else                       cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_PHASE_B: begin
        if (abort_hit)                                        state_d = ST_IDLE;
        else if (mode_q == DELAYED_OPERATE || cnt_q == w_last) state_d = ST_DONE;
        else                                                  cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    grant   = (busy && !abort_hit) ? owner_oh : '0;
    done    = (state_q == ST_DONE) ? owner_oh : '0;
    aborted = abort_hit ? owner_oh : '0;
    out     = 1'b1;
    case (state_q)
      ST_PHASE_A: out = has_phase_b(mode_q);
      ST_PHASE_B: out = 1'b0;
      default:    out = 1'b1;
    endcase
    if (abort_hit) out = 1'b1;
  end

endmodule
